functional_unit_dispatcher: RTL and testbench
=============================================

// Module: functional_unit_dispatcher
// PURPOSE
//  Sits between the reorder-buffer dispatch port and the functional units (FUs).
//  Routes each dispatched op to its FU and tracks per-FU occupancy, which drives availableFunctionalUnits.
//  Captures FU results and arbitrates them round-robin onto the single result-broadcast bus read by the ROB.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width
//  TAG_WIDTH    4  ROB tag width
//  EXEC_WIDTH   2  FU index width; NFU = 2**EXEC_WIDTH units
// PORTS
//  clk                       in   1               clock
//  rst                       in   1               sync reset, active-high
//  halt                      in   1               freeze all state; no issue, no capture, no broadcast change
//  dispatch                  in   1               ROB dispatch strobe
//  op1, op2                  in   DATA_WIDTH      operands
//  executionID_DU            in   EXEC_WIDTH      target FU index
//  executionTag              in   TAG_WIDTH       ROB tag of op
//  availableFunctionalUnits  out  NFU             bit i = FU i can take a dispatch
//  fu_issue_valid            out  NFU             one-cycle issue pulse per FU
//  fu_op1, fu_op2            out  DATA_WIDTH      registered operands (shared by all FUs)
//  fu_tag                    out  TAG_WIDTH       registered tag of issued op
//  fu_done_valid             in   NFU             FU i has a result
//  fu_done_data              in   NFU*DATA_WIDTH  FU i result, slice [i*DATA_WIDTH +: DATA_WIDTH]
//  fu_done_ready             out  NFU             dispatcher accepts FU i result
//  broadcastDataAvailable    out  1               broadcast slot valid
//  broadcastDestinationTag   out  TAG_WIDTH       tag of broadcast result
//  broadcastDestinationData  out  DATA_WIDTH      broadcast result
//  broadcastAccept           in   1               consumer took slot this cycle
//  dispatch_error            out  1               sticky: dispatch to non-idle FU
// BEHAVIOUR
//  Reset: all FUs IDLE, rr pointer 0, error 0.
//   All registered outputs 0; availableFunctionalUnits all 1 if halt=0.
//  Per-FU FSM, states IDLE, BUSY, RESULT.
//  - IDLE->BUSY: dispatch & id==i & ~halt. Tag is stored.
//    Next cycle: fu_issue_valid[i]=1 for exactly 1 cycle; fu_op1/op2/tag hold the dispatched values.
//  - BUSY: fu_done_ready[i]=1. fu_done_valid[i] latches data and moves the FU to RESULT.
//  - RESULT: requests the broadcast slot. When granted, result moves to the slot and the FU goes to IDLE.
//  availableFunctionalUnits[i] = (state==IDLE) & ~halt & ~(dispatch & id==i). This is combinational.
//   It stops a second dispatch to the same FU in the cycle the first is seen.
//  Dispatch to a non-IDLE FU: the op is ignored, no state change, dispatch_error<=1 (cleared only by rst).
//  fu_done_valid[i] outside BUSY is ignored.
//  Broadcast slot: a single register.
//   - Loadable when empty, or when broadcastAccept=1 this cycle (back-to-back, no bubble).
//   - Outputs are held stable while valid and not accepted.
//   - Accept with no RESULT FU pending: slot empties next cycle.
//  Arbiter: round-robin among RESULT FUs, searching from rr pointer upward with wrap NFU-1 -> 0.
//   On grant, pointer = winner+1 mod NFU.
//  Latency: done at cycle n -> RESULT at n+1 -> broadcast valid and FU IDLE at n+2 (slot free).
//  Simultaneous: in one cycle a FU may be granted and go IDLE, and another FU accept a dispatch.
//   Dispatch to a FU being granted that cycle is an error (it was not IDLE).
//  halt: every register holds; fu_issue_valid forced 0 during halt, pending pulse re-emitted after.
//  rst mid-operation: in-flight results and slot are discarded; FUs must also be reset.
// TESTING
//  1. Reset, halt=0 -> avail=4'b1111, broadcastDataAvailable=0, fu_issue_valid=0.
//  2. dispatch id=2 tag=5 op1=7 op2=3 -> next cycle fu_issue_valid=4'b0100, fu_tag=5; avail[2]=0 same cycle.
//     fu_done_valid[2] data=10 -> 2 cycles later broadcast tag=5 data=10; avail[2]=1.
//  3. FUs 0,1,3 finish the same cycle, broadcastAccept=1 always, ptr=0 -> broadcasts from FU 0,1,3 on 3 consecutive cycles.
//  4. Slot full, broadcastAccept=0 for 5 cycles -> tag/data stable; second RESULT FU waits, avail stays 0.
//  5. Second dispatch to id=1 while FU 1 BUSY -> no issue pulse, dispatch_error=1 persists until rst.
//  6. halt=1 during issue cycle -> no pulse; pulse on first cycle after halt=0. rst mid-BUSY -> all IDLE, slot empty.

Source files
------------

// File: rtl/functional_unit_dispatcher_if.sv
// Bundle between the ROB/FU side and the functional unit dispatcher.
//  slave  : the dispatcher itself
//  master : the environment (ROB dispatch port, FUs, broadcast consumer)
// Signals: halt, dispatch/op1/op2/executionID_DU/executionTag (dispatch in),
//  availableFunctionalUnits, fu_issue_valid/fu_op1/fu_op2/fu_tag (issue out),
//  fu_done_valid/fu_done_data in, fu_done_ready out,
//  broadcastDataAvailable/Tag/Data out, broadcastAccept in, dispatch_error out.
interface functional_unit_dispatcher_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int EXEC_WIDTH = 2
);
  localparam int NFU = 2**EXEC_WIDTH;

  logic                      halt;
  logic                      dispatch;
  logic [DATA_WIDTH-1:0]     op1;
  logic [DATA_WIDTH-1:0]     op2;
  logic [EXEC_WIDTH-1:0]     executionID_DU;
  logic [TAG_WIDTH-1:0]      executionTag;
  logic [NFU-1:0]            availableFunctionalUnits;
  logic [NFU-1:0]            fu_issue_valid;
  logic [DATA_WIDTH-1:0]     fu_op1;
  logic [DATA_WIDTH-1:0]     fu_op2;
  logic [TAG_WIDTH-1:0]      fu_tag;
  logic [NFU-1:0]            fu_done_valid;
  logic [NFU*DATA_WIDTH-1:0] fu_done_data;
  logic [NFU-1:0]            fu_done_ready;
  logic                      broadcastDataAvailable;
  logic [TAG_WIDTH-1:0]      broadcastDestinationTag;
  logic [DATA_WIDTH-1:0]     broadcastDestinationData;
  logic                      broadcastAccept;
  logic                      dispatch_error;

  modport slave (
    input  halt, dispatch, op1, op2, executionID_DU, executionTag,
           fu_done_valid, fu_done_data, broadcastAccept,
    output availableFunctionalUnits, fu_issue_valid, fu_op1, fu_op2, fu_tag,
           fu_done_ready, broadcastDataAvailable, broadcastDestinationTag,
           broadcastDestinationData, dispatch_error
  );

  modport master (
    output halt, dispatch, op1, op2, executionID_DU, executionTag,
           fu_done_valid, fu_done_data, broadcastAccept,
    input  availableFunctionalUnits, fu_issue_valid, fu_op1, fu_op2, fu_tag,
           fu_done_ready, broadcastDataAvailable, broadcastDestinationTag,
           broadcastDestinationData, dispatch_error
  );
endinterface

// File: rtl/functional_unit_dispatcher.sv
// Functional unit dispatcher: routes ROB dispatches to FUs, tracks per-FU
// occupancy (IDLE/BUSY/RESULT) and arbitrates finished results round-robin
// onto a single registered broadcast slot.
// Ports: clk, rst (sync, active-high), bus (functional_unit_dispatcher_if.slave).

// Per-FU controller: occupancy FSM, stored tag/result and the pending
// issue pulse. Everything freezes while halt is high.
module fud_fu_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt,
  input  logic                  disp_hit,   // dispatch addressed here, halt already masked
  input  logic [TAG_WIDTH-1:0]  tag_in,
  input  logic                  done_valid,
  input  logic [DATA_WIDTH-1:0] done_data,
  input  logic                  grant,
  output logic                  idle,
  output logic                  ready,
  output logic                  req,
  output logic                  issue_pend,
  output logic [TAG_WIDTH-1:0]  tag,
  output logic [DATA_WIDTH-1:0] data
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] RESULT = 2'd2;

  logic [1:0] state;

  assign idle  = (state == IDLE);
  assign ready = (state == BUSY) & ~halt;
  assign req   = (state == RESULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      issue_pend <= 1'b0;
      tag        <= '0;
      data       <= '0;
    end else if (!halt) begin
      // pulse lasts one unhalted cycle; a halt simply delays it
      issue_pend <= disp_hit & idle;
      case (state)
        IDLE:   if (disp_hit) begin state <= BUSY; tag <= tag_in; end
        BUSY:   if (done_valid) begin state <= RESULT; data <= done_data; end
        RESULT: if (grant) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module functional_unit_dispatcher #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int EXEC_WIDTH = 2
) (
  input logic clk,
  input logic rst,
  functional_unit_dispatcher_if.slave bus
);
  localparam int NFU = 2**EXEC_WIDTH;

  logic [NFU-1:0]                 fu_idle, fu_req, fu_grant, fu_hit, fu_pend;
  logic [NFU-1:0][TAG_WIDTH-1:0]  fu_res_tag;
  logic [NFU-1:0][DATA_WIDTH-1:0] fu_res_data;

  logic                  bc_vld;
  logic [TAG_WIDTH-1:0]  bc_tag;
  logic [DATA_WIDTH-1:0] bc_data;
  logic [EXEC_WIDTH-1:0] rr_ptr, win, idx;
  logic                  found, slot_load;
  logic                  err;
  logic [DATA_WIDTH-1:0] op1_q, op2_q;
  logic [TAG_WIDTH-1:0]  tag_q;

  logic disp_ok;
  assign disp_ok = bus.dispatch & ~bus.halt;

  for (genvar i = 0; i < NFU; i++) begin : g_fu
    assign fu_hit[i] = disp_ok & (bus.executionID_DU == EXEC_WIDTH'(i));

    fud_fu_ctrl #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_fu (
      .clk       (clk),
      .rst       (rst),
      .halt      (bus.halt),
      .disp_hit  (fu_hit[i]),
      .tag_in    (bus.executionTag),
      .done_valid(bus.fu_done_valid[i]),
      .done_data (bus.fu_done_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .grant     (fu_grant[i]),
      .idle      (fu_idle[i]),
      .ready     (bus.fu_done_ready[i]),
      .req       (fu_req[i]),
      .issue_pend(fu_pend[i]),
      .tag       (fu_res_tag[i]),
      .data      (fu_res_data[i])
    );

    // also blocks a second dispatch to the same FU in the cycle the first is seen
    assign bus.availableFunctionalUnits[i] = fu_idle[i] & ~bus.halt &
      ~(bus.dispatch & (bus.executionID_DU == EXEC_WIDTH'(i)));
  end

  assign bus.fu_issue_valid = fu_pend & {NFU{~bus.halt}};

  // Round-robin search upward from rr_ptr; index arithmetic wraps naturally
  // because NFU is a power of two.
  always_comb begin
    fu_grant  = '0;
    win       = '0;
    idx       = '0;
    found     = 1'b0;
    slot_load = ~bus.halt & (~bc_vld | bus.broadcastAccept);
    for (int k = 0; k < NFU; k++) begin
      idx = rr_ptr + EXEC_WIDTH'(k);
      if (!found && fu_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found && slot_load) fu_grant[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bc_vld  <= 1'b0;
      bc_tag  <= '0;
      bc_data <= '0;
      rr_ptr  <= '0;
    end else if (slot_load) begin
      if (found) begin
        bc_vld  <= 1'b1;
        bc_tag  <= fu_res_tag[win];
        bc_data <= fu_res_data[win];
        rr_ptr  <= win + EXEC_WIDTH'(1);
      end else if (bus.broadcastAccept) begin
        bc_vld <= 1'b0;
      end
    end
  end

  // Shared issue operands: only an accepted dispatch updates them.
  always_ff @(posedge clk) begin
    if (rst) begin
      op1_q <= '0;
      op2_q <= '0;
      tag_q <= '0;
      err   <= 1'b0;
    end else if (disp_ok) begin
      if (fu_idle[bus.executionID_DU]) begin
        op1_q <= bus.op1;
        op2_q <= bus.op2;
        tag_q <= bus.executionTag;
      end else begin
        err <= 1'b1;
      end
    end
  end

  assign bus.fu_op1                   = op1_q;
  assign bus.fu_op2                   = op2_q;
  assign bus.fu_tag                   = tag_q;
  assign bus.dispatch_error           = err;
  assign bus.broadcastDataAvailable   = bc_vld;
  assign bus.broadcastDestinationTag  = bc_tag;
  assign bus.broadcastDestinationData = bc_data;
endmodule

// File: tb/tb_functional_unit_dispatcher.sv
module tb_functional_unit_dispatcher;
  localparam int DW = 32, TW = 4, EW = 2, N = 4;

  logic clk, rst;
  int vectors = 0, miscompares = 0;

  functional_unit_dispatcher_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .EXEC_WIDTH(EW)) bus ();
  functional_unit_dispatcher #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .EXEC_WIDTH(EW)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 busy (waiting for result), 2 result held
  int          m_st[N];
  logic [TW-1:0] m_tag[N];
  logic [DW-1:0] m_data[N];
  bit          m_pend[N];
  logic [DW-1:0] m_op1, m_op2;
  logic [TW-1:0] m_ftag;
  bit          m_err, m_bv;
  int          m_ptr;
  logic [TW-1:0] m_btag;
  logic [DW-1:0] m_bdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_tag[i] = '0; m_data[i] = '0; m_pend[i] = 0;
    end
    m_op1 = '0; m_op2 = '0; m_ftag = '0; m_err = 0; m_bv = 0; m_ptr = 0;
    m_btag = '0; m_bdata = '0;
  endtask

  task automatic model_update();
    int nst[N];
    int w;
    bit found;
    int id;
    if (rst) begin model_reset(); return; end
    if (bus.halt) return;
    for (int i = 0; i < N; i++) nst[i] = m_st[i];
    found = 0; w = 0;
    if (!m_bv || bus.broadcastAccept) begin
      for (int k = 0; k < N; k++)
        if (!found && m_st[(m_ptr + k) % N] == 2) begin found = 1; w = (m_ptr + k) % N; end
      if (found) begin
        m_bv = 1; m_btag = m_tag[w]; m_bdata = m_data[w]; nst[w] = 0; m_ptr = (w + 1) % N;
      end else if (bus.broadcastAccept) m_bv = 0;
    end
    for (int i = 0; i < N; i++)
      if (m_st[i] == 1 && bus.fu_done_valid[i]) begin
        nst[i] = 2; m_data[i] = bus.fu_done_data[i*DW +: DW];
      end
    for (int i = 0; i < N; i++) m_pend[i] = 0;
    if (bus.dispatch) begin
      id = int'(bus.executionID_DU);
      if (m_st[id] == 0) begin
        nst[id] = 1; m_tag[id] = bus.executionTag; m_pend[id] = 1;
        m_op1 = bus.op1; m_op2 = bus.op2; m_ftag = bus.executionTag;
      end else m_err = 1;
    end
    for (int i = 0; i < N; i++) m_st[i] = nst[i];
  endtask

  task automatic check_all();
    logic [N-1:0] ea, ei, er;
    for (int i = 0; i < N; i++) begin
      ea[i] = (m_st[i] == 0) && !bus.halt && !(bus.dispatch && bus.executionID_DU == EW'(i));
      ei[i] = m_pend[i] && !bus.halt;
      er[i] = (m_st[i] == 1) && !bus.halt;
    end
    chk("avail", 64'(bus.availableFunctionalUnits), 64'(ea));
    chk("issue", 64'(bus.fu_issue_valid), 64'(ei));
    chk("ready", 64'(bus.fu_done_ready), 64'(er));
    chk("fu_op1", 64'(bus.fu_op1), 64'(m_op1));
    chk("fu_op2", 64'(bus.fu_op2), 64'(m_op2));
    chk("fu_tag", 64'(bus.fu_tag), 64'(m_ftag));
    chk("err", 64'(bus.dispatch_error), 64'(m_err));
    chk("bc_valid", 64'(bus.broadcastDataAvailable), 64'(m_bv));
    if (m_bv) begin
      chk("bc_tag", 64'(bus.broadcastDestinationTag), 64'(m_btag));
      chk("bc_data", 64'(bus.broadcastDestinationData), 64'(m_bdata));
    end
  endtask

  // called at posedge+1; compares before the next edge, then advances model
  task automatic step();
    #2;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    bus.halt = 0; bus.dispatch = 0; bus.op1 = '0; bus.op2 = '0;
    bus.executionID_DU = '0; bus.executionTag = '0;
    bus.fu_done_valid = '0; bus.fu_done_data = '0; bus.broadcastAccept = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; step(); step(); rst = 0;
  endtask

  task automatic disp(input int id, input int tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.dispatch = 1; bus.executionID_DU = EW'(id); bus.executionTag = TW'(tag);
    bus.op1 = a; bus.op2 = b;
  endtask

  initial begin
    logic [N*DW-1:0] dd;
    model_reset();
    rst = 1;
    idle_inputs();
    @(posedge clk); #1;
    do_reset();

    // 1: reset state
    #1;
    chk("rst_avail", 64'(bus.availableFunctionalUnits), 64'hF);
    chk("rst_bcv", 64'(bus.broadcastDataAvailable), 64'h0);
    chk("rst_issue", 64'(bus.fu_issue_valid), 64'h0);
    chk("rst_bdata", 64'(bus.broadcastDestinationData), 64'h0);

    // 2: single op end-to-end
    disp(2, 5, 7, 3);
    #1 chk("t2_avail_same", 64'(bus.availableFunctionalUnits), 64'hB);
    step();
    bus.dispatch = 0;
    #1 chk("t2_issue", 64'(bus.fu_issue_valid), 64'h4);
    chk("t2_tag", 64'(bus.fu_tag), 64'h5);
    bus.fu_done_valid = 4'b0100; dd = '0; dd[2*DW +: DW] = 32'd10; bus.fu_done_data = dd;
    step();
    bus.fu_done_valid = '0;
    step(); step();
    #1 chk("t2_bcv", 64'(bus.broadcastDataAvailable), 64'h1);
    chk("t2_btag", 64'(bus.broadcastDestinationTag), 64'h5);
    chk("t2_bdata", 64'(bus.broadcastDestinationData), 64'd10);
    chk("t2_avail", 64'(bus.availableFunctionalUnits[2]), 64'h1);

    // 3: three simultaneous finishes, always accepted
    do_reset();
    disp(0, 8, 1, 1); step();
    disp(1, 9, 2, 2); step();
    disp(3, 11, 3, 3); step();
    bus.dispatch = 0; bus.broadcastAccept = 1;
    bus.fu_done_valid = 4'b1011;
    dd = '0; dd[0 +: DW] = 32'd100; dd[DW +: DW] = 32'd101; dd[3*DW +: DW] = 32'd103;
    bus.fu_done_data = dd;
    step();
    bus.fu_done_valid = '0;
    step(); #1 chk("t3_b0", 64'(bus.broadcastDestinationTag), 64'd8);
    step(); #1 chk("t3_b1", 64'(bus.broadcastDestinationTag), 64'd9);
    step(); #1 chk("t3_b3", 64'(bus.broadcastDestinationTag), 64'd11);
    chk("t3_d3", 64'(bus.broadcastDestinationData), 64'd103);
    step(); #1 chk("t3_empty", 64'(bus.broadcastDataAvailable), 64'h0);

    // 4: back-pressure holds the slot and the second result
    do_reset();
    disp(0, 1, 0, 0); step();
    disp(1, 2, 0, 0); step();
    bus.dispatch = 0; bus.fu_done_valid = 4'b0011;
    dd = '0; dd[0 +: DW] = 32'd100; dd[DW +: DW] = 32'd200; bus.fu_done_data = dd;
    step();
    bus.fu_done_valid = '0;
    step();
    for (int c = 0; c < 5; c++) begin
      #1 chk("t4_hold_tag", 64'(bus.broadcastDestinationTag), 64'd1);
      chk("t4_hold_data", 64'(bus.broadcastDestinationData), 64'd100);
      chk("t4_avail1", 64'(bus.availableFunctionalUnits[1]), 64'h0);
      step();
    end
    bus.broadcastAccept = 1;
    step(); #1 chk("t4_second", 64'(bus.broadcastDestinationData), 64'd200);
    step(); #1 chk("t4_empty", 64'(bus.broadcastDataAvailable), 64'h0);
    bus.broadcastAccept = 0;

    // 5: dispatch into a busy FU
    do_reset();
    disp(1, 3, 5, 5); step();
    disp(1, 4, 6, 6); step();
    bus.dispatch = 0;
    #1 chk("t5_nopulse", 64'(bus.fu_issue_valid), 64'h0);
    chk("t5_err", 64'(bus.dispatch_error), 64'h1);
    chk("t5_tag_kept", 64'(bus.fu_tag), 64'd3);
    step(); step(); step();
    #1 chk("t5_sticky", 64'(bus.dispatch_error), 64'h1);
    do_reset();
    #1 chk("t5_cleared", 64'(bus.dispatch_error), 64'h0);

    // 6: halt over the issue cycle, then reset mid-operation
    disp(0, 6, 32'h11, 32'h22); step();
    bus.dispatch = 0; bus.halt = 1;
    #1 chk("t6_halt_issue", 64'(bus.fu_issue_valid), 64'h0);
    chk("t6_halt_avail", 64'(bus.availableFunctionalUnits), 64'h0);
    step(); step();
    bus.halt = 0;
    #1 chk("t6_reissue", 64'(bus.fu_issue_valid), 64'h1);
    chk("t6_tag", 64'(bus.fu_tag), 64'd6);
    step();
    #1 chk("t6_once", 64'(bus.fu_issue_valid), 64'h0);
    disp(2, 7, 0, 0); bus.fu_done_valid = 4'b0001; step();
    bus.dispatch = 0; bus.fu_done_valid = '0; step();
    rst = 1; step(); rst = 0;
    #1 chk("t6_rst_avail", 64'(bus.availableFunctionalUnits), 64'hF);
    chk("t6_rst_bcv", 64'(bus.broadcastDataAvailable), 64'h0);
    step(); step();

    // random traffic against the model
    for (int c = 0; c < 800; c++) begin
      bus.dispatch = ($urandom_range(0, 1) == 1);
      bus.executionID_DU = EW'($urandom_range(0, N - 1));
      bus.executionTag = TW'($urandom);
      bus.op1 = $urandom; bus.op2 = $urandom;
      bus.fu_done_valid = N'($urandom);
      bus.fu_done_data = {$urandom, $urandom, $urandom, $urandom};
      bus.broadcastAccept = ($urandom_range(0, 9) < 6);
      bus.halt = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0;
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
